// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle unsigned WIDTH x WIDTH shift-add multiplier.
// It performs one add-and-shift step per clock and hands a 2*WIDTH-bit product
// plus its opcode to the HiLo accumulator.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous active-high reset; it has priority over every other input
//   start  - requests a new multiply; it is sampled only in IDLE or DONE
//   op     - opcode captured with the operands (MULTU=1, MADDU=28)
//   a, b   - multiplicand and multiplier
//   busy   - high while the iterations run
//   done   - one-cycle pulse; MulAns/op_out are valid from this cycle onward
//   MulAns - registered product; it updates only on the edge that enters DONE
//   op_out - opcode belonging to the current MulAns
module seq_multiplier #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [5:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   MulAns,
    output logic [5:0]           op_out
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} stateT;

    stateT              stateQ, stateD;
    logic [2*WIDTH-1:0] prodQ, prodD;
    logic [WIDTH-1:0]   mcandQ, mcandD;
    logic [CNT_W-1:0]   cntQ, cntD;
    logic [5:0]         opQ, opD;
    logic [2*WIDTH-1:0] ansQ, ansD;
    logic [5:0]         opOutQ, opOutD;

    // The upper half plus the carry of the add step. The carry lands in the MSB
    // of the product after the shift, so it is never lost.
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            prodQ  <= '0;
            mcandQ <= '0;
            cntQ   <= '0;
            opQ    <= '0;
            ansQ   <= '0;
            opOutQ <= '0;
        end else begin
            stateQ <= stateD;
            prodQ  <= prodD;
            mcandQ <= mcandD;
            cntQ   <= cntD;
            opQ    <= opD;
            ansQ   <= ansD;
            opOutQ <= opOutD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        prodD   = prodQ;
        mcandD  = mcandQ;
        cntD    = cntQ;
        opD     = opQ;
        ansD    = ansQ;
        opOutD  = opOutQ;
        sum     = '0;
        shifted = '0;

        unique case (stateQ)
            StIdle, StDone: begin
                if (start) begin
                    stateD = StRun;
                    mcandD = a;
                    prodD  = {{WIDTH{1'b0}}, b};
                    cntD   = '0;
                    opD    = op;
                end else begin
                    stateD = StIdle;
                end
            end
            StRun: begin
                if (prodQ[0]) begin
                    sum = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + {1'b0, mcandQ};
                end else begin
                    sum = {1'b0, prodQ[2*WIDTH-1:WIDTH]};
                end
                // Right shift of {sum, low half}: the consumed multiplier bit drops off.
                shifted = {sum, prodQ[WIDTH-1:1]};
                prodD   = shifted;
                cntD    = cntQ + CNT_W'(1);
                if (cntQ == CNT_W'(WIDTH - 1)) begin
                    stateD = StDone;
                    ansD   = shifted;
                    opOutD = opQ;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign busy   = (stateQ == StRun);
    assign done   = (stateQ == StDone);
    assign MulAns = ansQ;
    assign op_out = opOutQ;

endmodule
